// File: rtl/mult_frac_core_pipe.sv
// mult_frac_core_pipe: configurable fracturable multiplier core with optional
// input/output pipeline registers, clock-enable stall and valid tracking.
// Mode bits are loaded through a 5-bit serial configuration chain.
//
// Ports:
//   prog_clk       single clock for config chain and datapath
//   pReset         synchronous active-high reset
//   config_enable  1 = shift config chain and flush the datapath
//   ccff_head      config chain serial in
//   ccff_tail      config chain serial out (cfg[4])
//   in_valid       operands valid this cycle
//   ce             pipeline advance enable, 0 = stall
//   a, b           operands, index 0 = LSB
//   out            product, index 0 = LSB
//   out_valid      out holds a valid result
module mult_frac_core_pipe #(
  parameter int unsigned WIDTH    = 18,
  parameter int unsigned CFG_BITS = 5
) (
  input  logic               prog_clk,
  input  logic               pReset,
  input  logic               config_enable,
  input  logic               ccff_head,
  output logic               ccff_tail,
  input  logic               in_valid,
  input  logic               ce,
  input  logic [0:WIDTH-1]   a,
  input  logic [0:WIDTH-1]   b,
  output logic [0:2*WIDTH-1] out,
  output logic               out_valid
);

  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned PW = 2 * WIDTH;

  // Elaboration-time parameter legality checks
  if (CFG_BITS != 5) begin : g_bad_cfg_bits
    $error("mult_frac_core_pipe: CFG_BITS must be 5");
  end
  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("mult_frac_core_pipe: WIDTH must be even and >= 4");
  end

  // Configuration chain state and decoded mode bits
  logic [CFG_BITS-1:0] cfg_q, cfg_d;
  logic frac, signed_a, signed_b, in_reg_en, out_reg_en;

  assign frac       = cfg_q[0];
  assign signed_a   = cfg_q[1];
  assign signed_b   = cfg_q[2];
  assign in_reg_en  = cfg_q[3];
  assign out_reg_en = cfg_q[4];
  assign ccff_tail  = cfg_q[CFG_BITS-1];

  // Ports are ascending-indexed with bit 0 as LSB; remap to descending vectors
  logic [WIDTH-1:0] a_n, b_n;
  logic [PW-1:0]    out_n;

  for (genvar i = 0; i < WIDTH; i++) begin : g_in_map
    assign a_n[i] = a[i];
    assign b_n[i] = b[i];
  end
  for (genvar i = 0; i < PW; i++) begin : g_out_map
    assign out[i] = out_n[i];
  end

  // Pipeline registers
  logic [WIDTH-1:0] a_in_q, a_in_d, b_in_q, b_in_d;
  logic             v_in_q, v_in_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic             v_mul_q, v_mul_d;
  logic [PW-1:0]    out_q, out_d;
  logic             v_out_q, v_out_d;

  // S_in bypass when the input stage is disabled
  logic [WIDTH-1:0] a_s, b_s;
  logic             v_s;

  assign a_s = in_reg_en ? a_in_q : a_n;
  assign b_s = in_reg_en ? b_in_q : b_n;
  assign v_s = in_reg_en ? v_in_q : in_valid;

  // Multiplier: operands are sign- or zero-extended to the product width so a
  // plain unsigned multiply yields the correct two's-complement result.
  logic [PW-1:0]    a_ext, b_ext, prod_full, prod_c;
  logic [WIDTH-1:0] al_ext, bl_ext, ah_ext, bh_ext, prod_lo, prod_hi;

  always_comb begin
    a_ext     = {{WIDTH{signed_a & a_s[WIDTH-1]}}, a_s};
    b_ext     = {{WIDTH{signed_b & b_s[WIDTH-1]}}, b_s};
    prod_full = a_ext * b_ext;
    al_ext    = {{H{signed_a & a_s[H-1]}}, a_s[H-1:0]};
    bl_ext    = {{H{signed_b & b_s[H-1]}}, b_s[H-1:0]};
    ah_ext    = {{H{signed_a & a_s[WIDTH-1]}}, a_s[WIDTH-1:H]};
    bh_ext    = {{H{signed_b & b_s[WIDTH-1]}}, b_s[WIDTH-1:H]};
    prod_lo   = al_ext * bl_ext;
    prod_hi   = ah_ext * bh_ext;
    prod_c    = frac ? {prod_hi, prod_lo} : prod_full;
  end

  // Next-state: config shift flushes valids; ce gates every stage together.
  // Data registers load only with valid data so out holds between results.
  always_comb begin
    cfg_d   = cfg_q;
    a_in_d  = a_in_q;
    b_in_d  = b_in_q;
    v_in_d  = v_in_q;
    prod_d  = prod_q;
    v_mul_d = v_mul_q;
    out_d   = out_q;
    v_out_d = v_out_q;
    if (config_enable) begin
      cfg_d   = {cfg_q[CFG_BITS-2:0], ccff_head};
      v_in_d  = 1'b0;
      v_mul_d = 1'b0;
      v_out_d = 1'b0;
    end else if (ce) begin
      v_in_d = in_valid;
      if (in_valid) begin
        a_in_d = a_n;
        b_in_d = b_n;
      end
      v_mul_d = v_s;
      if (v_s) begin
        prod_d = prod_c;
      end
      v_out_d = v_mul_q;
      if (v_mul_q) begin
        out_d = prod_q;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      cfg_q   <= '0;
      a_in_q  <= '0;
      b_in_q  <= '0;
      v_in_q  <= 1'b0;
      prod_q  <= '0;
      v_mul_q <= 1'b0;
      out_q   <= '0;
      v_out_q <= 1'b0;
    end else begin
      cfg_q   <= cfg_d;
      a_in_q  <= a_in_d;
      b_in_q  <= b_in_d;
      v_in_q  <= v_in_d;
      prod_q  <= prod_d;
      v_mul_q <= v_mul_d;
      out_q   <= out_d;
      v_out_q <= v_out_d;
    end
  end

  // S_out bypass when the output stage is disabled
  assign out_n     = out_reg_en ? out_q : prod_q;
  assign out_valid = out_reg_en ? v_out_q : v_mul_q;

endmodule

// File: doc/mult_frac_core_pipe.md
Name: mult_frac_core_pipe

Overview:
Parametrised successor to the fixed 18x18 multiplier core tile. It adds runtime-configurable fracturing into one WIDTHxWIDTH or two (WIDTH/2)x(WIDTH/2) products, per-operand signedness, optional input and output pipeline registers, clock-enable stall and valid tracking. All mode bits are loaded through the standard ccff configuration chain. It sits inside the mult logical tile in place of the fixed core.

Parameters:
WIDTH, 18, operand width; must be even and >= 4. H = WIDTH/2.
CFG_BITS, 5, length of the configuration chain; fixed at 5. Other values are illegal and rejected by elaboration check.

Ports:
prog_clk  input  1  single clock for the config chain and the datapath.
pReset  input  1  synchronous active-high reset.
config_enable  input  1  1 = shift config chain, datapath flushed.
ccff_head  input  1  config chain serial in.
ccff_tail  output  1  config chain serial out.
in_valid  input  1  operands valid this cycle.
ce  input  1  pipeline advance enable; 0 = stall.
a  input  [0:WIDTH-1]  operand A; index 0 = LSB.
b  input  [0:WIDTH-1]  operand B; index 0 = LSB.
out  output  [0:2*WIDTH-1]  product; index 0 = LSB.
out_valid  output  1  out holds a valid result.

Behaviour:
- Clocking and reset: one clock, prog_clk. Reset is synchronous and active-high on pReset. pReset has priority over config_enable, which has priority over ce.
- On pReset: cfg[0:4], every pipeline data register, every valid flag, out, out_valid and ccff_tail all go to 0.
- Config chain, when config_enable=1:
  - cfg[0] <= ccff_head; cfg[i] <= cfg[i-1].
  - ccff_tail = cfg[4], registered with no combinational path from ccff_head.
  - The first bit shifted in lands in cfg[4] after 5 cycles.
- Config bit map: cfg[0]=frac (0 = one WIDTHxWIDTH, 1 = two HxH); cfg[1]=signed_a; cfg[2]=signed_b; cfg[3]=in_reg_en; cfg[4]=out_reg_en.
- cfg holds when config_enable=0. Mode changes therefore only occur while the datapath is flushed.
- During config_enable=1: every valid flag is cleared each cycle and out_valid=0. Data registers hold. in_valid is ignored.
- Pipeline has three stages:
  - S_in: present only if in_reg_en; registers a, b and in_valid.
  - S_mul: always present; registers the product and its valid.
  - S_out: present only if out_reg_en; registers out and out_valid.
  - A disabled stage is a combinational bypass.
- Latency with ce=1 throughout: L = 1 + in_reg_en + out_reg_en cycles, i.e. 1 to 3, from in_valid sampled to out_valid asserted.
- Throughput: one operation per cycle, no bubbles.
- Stall: when ce=0, all stage registers and their valid flags hold. out and out_valid are stable.
- Arithmetic, frac=0: out = a*b at full width 2*WIDTH, no truncation.
  - signed_a=1 treats a as two's complement with sign bit a[WIDTH-1]; likewise signed_b for b.
  - Mixed signedness is legal, e.g. signed*unsigned.
  - The result is sign-extended when either operand is signed.
- Arithmetic, frac=1:
  - out[0:WIDTH-1] = a[0:H-1]*b[0:H-1].
  - out[WIDTH:2*WIDTH-1] = a[H:WIDTH-1]*b[H:WIDTH-1].
  - Each half product is 2H bits wide. Signedness per half uses sign bits a[H-1] and b[H-1] for the low half, a[WIDTH-1] and b[WIDTH-1] for the high half.
  - No carry crosses between the halves.
- out holds its last value when out_valid=0. It is not forced to 0 except by pReset.
- Reset mid-operation: in-flight results are discarded and out_valid=0 on the following cycle. cfg returns to 0, giving unsigned, unfractured, latency 1.
- Simultaneous pReset and config_enable: reset wins and no shift occurs.

Test Plan:
- Reset then config: pReset 1 cycle -> out=0, out_valid=0, ccff_tail=0. Shift ccff_head = 1,0,0,0,0 (out_reg_en first) -> cfg[4]=1, ccff_tail=1 on cycle 5.
- Unsigned full, cfg all 0 except out_reg_en=1: a=0x3FFFF, b=0x3FFFF with in_valid -> out=0xFFFF80001 with out_valid exactly 2 cycles later.
- Signed full, signed_a=signed_b=1, no regs: a=0x3FFFF (-1), b=3 -> out=0xFFFFFFFFD at latency 1. Mixed case: signed_a=1, signed_b=0, a=-1, b=0x3FFFF -> out=-(2^18-1) sign-extended, i.e. 0xFFFFC0001.
- Fractured, signed both: a = high 0x1FF, low 5; b = high 2, low 7 -> out[0:17]=0x00023, out[18:35]=0x3FFFE. Confirm no carry crosses halves.
- Stall and throughput, all regs enabled (L=3): 4 back-to-back in_valid ops with ce low for 2 cycles mid-stream -> 4 results in order, out_valid gaps exactly 2 cycles, out stable while ce=0.
- Flush: in_valid ops in flight, assert config_enable 1 cycle -> out_valid=0 the next cycle and no stale results emerge afterwards. Repeat with pReset mid-stream -> out=0, out_valid=0 the next cycle.
